uart_tx_serializer: RTL and testbench

- Downstream consumer of the byte FIFO on the console UART path. It drains 8-bit words from the FIFO read side, which is first-word-fall-through: data is valid whenever the FIFO is not empty, and a pop advances it.
- Serializes each word as an 8N1 frame on the tx line at a runtime-programmable bit period.
- Sits between the TX FIFO and the pad; the busy output feeds the UART status register.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 48 ++++
 rtl/uart_tx_serializer.sv | 145 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the console UART path.
//   state_t           - serializer state encoding (IDLE, START, DATA, PARITY, STOP)
//   START_BIT         - line level of the start bit
//   STOP_BIT          - line level of the stop bit (and idle level)
//   DEFAULT_DIV_WIDTH - default width of the bit-period divisor
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_DIV_WIDTH = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter shared by the UART transmitter and
// (later) the receiver.
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   load     - latch period and restart the count at period-1
//   enable   - count while high; holds otherwise
//   period   - clocks per bit; 0 is treated as 1
//   bit_tick - high for one clock on the last clock of every bit period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] period_reg;
  logic [DIV_WIDTH-1:0] count_reg;
  logic [DIV_WIDTH-1:0] period_eff;

  // Clamp to at least 1 so period-1 can never wrap below zero.
  assign period_eff = (period == '0) ? DIV_WIDTH'(1) : period;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      period_reg <= period_eff;
      count_reg  <= period_eff - DIV_WIDTH'(1);
    end else if (enable) begin
      if (count_reg == '0) begin
        // Auto-reload from the latched period so later bits keep the frame's rate.
        count_reg <= (period_reg == '0) ? '0 : period_reg - DIV_WIDTH'(1);
      end else begin
        count_reg <= count_reg - DIV_WIDTH'(1);
      end
    end
  end

  assign bit_tick = enable && (count_reg == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: drains words from a first-word-fall-through FIFO and
// sends each as an 8N1 frame (start, DATA_WIDTH bits LSB first, stop).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit.
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   div        - clocks per bit, sampled at each frame load (0 and 1 -> 1)
//   fifo_dout  - FIFO head word, valid while fifo_empty is low
//   fifo_empty - FIFO empty flag
//   fifo_pop   - one-cycle pop strobe (combinational)
//   tx         - serial line, idle high (registered)
//   busy       - high whenever a frame is in flight (registered)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  load;
  logic                  bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg;
`endif

  uart_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .enable  (state_reg != IDLE),
    .period  (div),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    load         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            shift_next   = shift_reg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        // Final stop clock: chain straight into the next frame if data waits.
        if (bit_tick) begin
          if (!fifo_empty) load = 1'b1;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      state_next   = START;
      shift_next   = fifo_dout;
      bit_cnt_next = '0;
    end

    // tx is registered, so it is derived from where the FSM is going next.
    case (state_next)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      default: tx_next = STOP_BIT;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= STOP_BIT;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     parity_reg <= 1'b0;
    else if (load) parity_reg <= ^fifo_dout;
  end
`endif

  assign fifo_pop = load;
  assign tx       = tx_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: self-checking bench for uart_tx_serializer.
// A queue-based FIFO feeds the DUT; a reference model turns every popped word
// into the expected per-clock tx levels and checks tx/busy/fifo_pop each cycle.
// Table vectors and hand-written sequences cover the listed corner cases.
module tb_uart_tx_serializer;

  localparam int DW  = 8;
  localparam int DVW = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [DVW-1:0] div;
  logic [DW-1:0]  fifo_dout;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           tx;
  logic           busy;

  uart_tx_serializer #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;

  logic [7:0] fq[$];    // FIFO contents
  bit         exp_q[$]; // expected tx level for each upcoming clock
  bit         model_on = 1'b0;
  logic       s_tx, s_busy, s_pop;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] dv;
    logic [10:0] bits; // bit 0 = first bit on the line (start)
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame = start, data LSB first, [even parity], stop; every bit lasts max(div,1) clocks.
  function automatic void push_frame(logic [7:0] d, logic [15:0] dv);
    int p;
    bit bits[$];
    p = (dv == 0) ? 1 : int'(dv);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[i])
      for (int r = 0; r < p; r++) exp_q.push_back(bits[i]);
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  // One clock: sample at the falling edge, run the model, apply the pop after the rising edge.
  task automatic cycle();
    bit etx, ebusy, epop;
    @(negedge clk);
    s_tx = tx; s_busy = busy; s_pop = fifo_pop;
    cyc++;
    if (s_pop) pops++;
    if (model_on) begin
      ebusy = (exp_q.size() > 0);
      etx   = ebusy ? exp_q.pop_front() : 1'b1;
      // A pop is due when idle or on the last clock of the current frame.
      epop  = (fq.size() > 0) && (exp_q.size() == 0);
      check("model_tx_busy_pop", {29'd0, s_tx, s_busy, s_pop}, {29'd0, etx, ebusy, epop});
      if (epop) push_frame(fq[0], div);
    end
    @(posedge clk);
    #1;
    if (s_pop && fq.size() > 0) fq.delete(0);
    drive_fifo();
  endtask

  task automatic wait_pop(string name);
    int n;
    n = 0;
    cycle();
    while (!s_pop && n < 20) begin
      cycle();
      n++;
    end
    check({name, "_pop_seen"}, s_pop, 1'b1);
  endtask

  vec_t vecs[$];

  initial begin
    int p, pops0, busy_cnt, pop2_at, guard;
    vec_t v;

`ifdef UART_TX_PARITY_EN
    vecs.push_back('{8'h55, 16'd4, 11'b10_01010101_0});
    vecs.push_back('{8'h07, 16'd1, 11'b11_00000111_0});
    vecs.push_back('{8'hFF, 16'd0, 11'b10_11111111_0});
    vecs.push_back('{8'h01, 16'd2, 11'b11_00000001_0});
    vecs.push_back('{8'h3C, 16'd3, 11'b10_00111100_0});
`else
    vecs.push_back('{8'h55, 16'd4, 11'b01_01010101_0});
    vecs.push_back('{8'hFF, 16'd0, 11'b01_11111111_0});
    vecs.push_back('{8'h00, 16'd1, 11'b01_00000000_0});
    vecs.push_back('{8'hA5, 16'd2, 11'b01_10100101_0});
    vecs.push_back('{8'h3C, 16'd3, 11'b01_00111100_0});
`endif

    // Reset and idle
    reset = 1'b1;
    div   = 16'd4;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_pop", fifo_pop, 1'b0);
    reset    = 1'b0;
    model_on = 1'b1;
    repeat (100) cycle();
    check("idle_no_pop", pops, 0);

    // Single frames from the table
    foreach (vecs[i]) begin
      v = vecs[i];
      fq.push_back(v.data);
      div = v.dv;
      drive_fifo();
      pops0 = pops;
      wait_pop("vec");
      p = (v.dv == 0) ? 1 : int'(v.dv);
      for (int k = 0; k < NB * p; k++) begin
        cycle();
        check("vec_tx_bit", s_tx, v.bits[k / p]);
        check("vec_busy", s_busy, 1'b1);
      end
      cycle();
      check("vec_busy_fall", s_busy, 1'b0);
      check("vec_one_pop", pops - pops0, 1);
      $display("vector %0d data=%02h div=%0d frame_clocks=%0d", i, v.data, v.dv, NB * p);
    end

    // Back-to-back frames, div=2
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    div = 16'd2;
    drive_fifo();
    wait_pop("b2b");
    busy_cnt = 0;
    pop2_at  = -1;
    for (int k = 1; k <= 2 * NB * 2 + 5; k++) begin
      cycle();
      if (s_busy) busy_cnt++;
      if (s_pop && pop2_at < 0) pop2_at = k;
      if (k == NB * 2)     check("b2b_stop_tx", s_tx, 1'b1);
      if (k == NB * 2 + 1) check("b2b_start_tx", s_tx, 1'b0);
    end
    check("b2b_second_pop_at", pop2_at, NB * 2);
    check("b2b_busy_clocks", busy_cnt, 2 * NB * 2);
    $display("back-to-back: second pop at +%0d busy clocks %0d", pop2_at, busy_cnt);

    // div changed from 8 to 3 in the middle of a frame
    fq.push_back(8'h0F);
    fq.push_back(8'hF0);
    div = 16'd8;
    drive_fifo();
    wait_pop("divchg");
    busy_cnt = 0;
    pop2_at  = -1;
    for (int k = 1; k <= NB * 8 + NB * 3 + 5; k++) begin
      if (k == 20) div = 16'd3;
      cycle();
      if (s_busy) busy_cnt++;
      if (s_pop && pop2_at < 0) pop2_at = k;
    end
    check("divchg_second_pop_at", pop2_at, NB * 8);
    check("divchg_busy_clocks", busy_cnt, NB * 8 + NB * 3);
    $display("div change: second pop at +%0d busy clocks %0d", pop2_at, busy_cnt);

    // Reset during data bit 3 of 0x00 at div=4
    fq.push_back(8'h00);
    div = 16'd4;
    drive_fifo();
    wait_pop("rst");
    repeat (17) cycle();
    check("rst_pre_tx", tx, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_async_tx", tx, 1'b1);
    check("rst_async_busy", busy, 1'b0);
    model_on = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    model_on = 1'b1;
    pops0    = pops;
    repeat (20) cycle();
    check("rst_stays_idle", pops - pops0, 0);
    fq.push_back(8'h5A);
    drive_fifo();
    wait_pop("rst_restart");
    repeat (NB * 4 + 1) cycle();
    check("rst_restart_done", busy, 1'b0);
    $display("reset mid-frame: async tx high, restart ok");

    // Randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) fq.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) div = 16'($urandom_range(0, 5));
      drive_fifo();
      repeat ($urandom_range(1, 30)) cycle();
    end
    guard = 0;
    while ((fq.size() > 0 || exp_q.size() > 0) && guard < 20000) begin
      cycle();
      guard++;
    end
    check("random_drained", fq.size() + exp_q.size(), 0);
    $display("random traffic: %0d clocks total, %0d pops", cyc, pops);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
